// File: rtl/problem_quad_reduce.sv
// -----------------------------------------------------------------------------
// problem_quad_reduce
//   Registered 4-input, 16-bit unsigned reduction stage. Every rising edge the
//   four operands and the opcode are sampled and one of sum, maximum, minimum
//   or floor-average is registered onto o_data (latency exactly one cycle).
//
// Ports:
//   i_clk              system clock, rising edge
//   i_rst_n            asynchronous active-low reset, clears o_data to 0
//   i_data_0..i_data_3 16-bit unsigned operands
//   i_ctrl             opcode: 00 SUM, 01 MAX, 10 MIN, 11 AVG
//   o_data             16-bit registered result
//
// Build option:
//   PROBLEM_SUM_SAT_EN defined   -> SUM saturates to 16'hFFFF
//   PROBLEM_SUM_SAT_EN undefined -> SUM wraps modulo 2^16 (default)
// -----------------------------------------------------------------------------
module problem_quad_reduce (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [15:0] i_data_0,
   input  logic [15:0] i_data_1,
   input  logic [15:0] i_data_2,
   input  logic [15:0] i_data_3,
   input  logic [1:0]  i_ctrl,
   output logic [15:0] o_data
);

   localparam logic [1:0] OpSum = 2'b00;
   localparam logic [1:0] OpMax = 2'b01;
   localparam logic [1:0] OpMin = 2'b10;
   localparam logic [1:0] OpAvg = 2'b11;

   // 18 bits hold the worst case 4 * 16'hFFFF = 18'h3FFFC without overflow.
   logic [17:0] sum_full;
   logic [15:0] sum_res;
   logic [15:0] max_01, max_23, max_all;
   logic [15:0] min_01, min_23, min_all;
   logic [15:0] result;

   assign sum_full = {2'b00, i_data_0} + {2'b00, i_data_1}
                   + {2'b00, i_data_2} + {2'b00, i_data_3};

`ifdef PROBLEM_SUM_SAT_EN
   assign sum_res = (sum_full[17:16] != 2'b00) ? 16'hFFFF : sum_full[15:0];
`else
   assign sum_res = sum_full[15:0];
`endif

   // Two-level comparator trees: pairs (0,1) and (2,3), then the winners.
   assign max_01  = (i_data_0 >= i_data_1) ? i_data_0 : i_data_1;
   assign max_23  = (i_data_2 >= i_data_3) ? i_data_2 : i_data_3;
   assign max_all = (max_01 >= max_23) ? max_01 : max_23;

   assign min_01  = (i_data_0 <= i_data_1) ? i_data_0 : i_data_1;
   assign min_23  = (i_data_2 <= i_data_3) ? i_data_2 : i_data_3;
   assign min_all = (min_01 <= min_23) ? min_01 : min_23;

   always_comb begin
      result = 16'h0000;
      unique case (i_ctrl)
         OpSum:   result = sum_res;
         OpMax:   result = max_all;
         OpMin:   result = min_all;
         OpAvg:   result = sum_full[17:2];  // floor(S / 4) always fits 16 bits
         default: result = 16'h0000;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_data <= 16'h0000;
      end else begin
         o_data <= result;
      end
   end

endmodule

// File: tb/tb_problem_quad_reduce.sv
// -----------------------------------------------------------------------------
// tb_problem_quad_reduce
//   Self-checking bench for problem_quad_reduce. Inputs are driven on the
//   falling edge, the expected result is pushed to a scoreboard queue, and the
//   registered output is popped and compared on the following falling edge.
// -----------------------------------------------------------------------------
module tb_problem_quad_reduce;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
   logic [1:0]  ctrl = '0;
   logic [15:0] o_data;

   int          n_tests = 0;
   int          n_fail = 0;
   logic [15:0] exp_q[$];

   problem_quad_reduce dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_data_0 (d0),
      .i_data_1 (d1),
      .i_data_2 (d2),
      .i_data_3 (d3),
      .i_ctrl   (ctrl),
      .o_data   (o_data)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1);
   end

   // Reference model built from the arithmetic definitions.
   function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c, input logic [15:0] d,
                                         input logic [1:0] op);
      int unsigned s;
      int unsigned v[4];
      int unsigned mx, mn;
      v[0] = a; v[1] = b; v[2] = c; v[3] = d;
      s = 0; mx = 0; mn = 32'hFFFF_FFFF;
      for (int k = 0; k < 4; k++) begin
         s = s + v[k];
         if (v[k] > mx) mx = v[k];
         if (v[k] < mn) mn = v[k];
      end
      case (op)
`ifdef PROBLEM_SUM_SAT_EN
         2'b00: return (s > 32'h0000_FFFF) ? 16'hFFFF : 16'(s);
`else
         2'b00: return 16'(s % 65536);
`endif
         2'b01: return 16'(mx);
         2'b10: return 16'(mn);
         default: return 16'(s / 4);
      endcase
   endfunction

   // Vector layout: {d0, d1, d2, d3, ctrl}
   task automatic drive(input logic [65:0] v);
      {d0, d1, d2, d3, ctrl} = v;
      exp_q.push_back(model(v[65:50], v[49:34], v[33:18], v[17:2], v[1:0]));
   endtask

   task automatic test_reset();
      logic [15:0] got;
      rst_n = 1'b0;
      d0 = 16'h1111; d1 = 16'h2222; d2 = 16'h3333; d3 = 16'h4444; ctrl = 2'b00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      got = o_data;
      n_tests++;
      if (got !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_hold: o_data=%h expected 0000", got);
      end
      // First update on the first rising edge after deassertion.
      rst_n = 1'b1;
      drive({16'h0010, 16'h0020, 16'h0030, 16'h0040, 2'b00});
      @(negedge clk);
      got = o_data;
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL reset_first: scoreboard empty, o_data=%h", got);
      end else if (got !== exp_q[0]) begin
         n_fail++;
         $display("FAIL reset_first: o_data=%h expected %h", got, exp_q[0]);
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
   endtask

   task automatic test_sum();
      logic [65:0] vec[3] = '{
         {16'h0001, 16'h0002, 16'h0003, 16'h0004, 2'b00},
         {16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 2'b00},
         {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2'b00}};
      logic [15:0] got, exp;
      for (int i = 0; i <= 3; i++) begin
         @(negedge clk);
         if (i > 0) begin
            got = o_data;
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL sum[%0d]: scoreboard empty, o_data=%h", i - 1, got);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp) begin
                  n_fail++;
                  $display("FAIL sum[%0d]: o_data=%h expected %h", i - 1, got, exp);
               end
            end
         end
         if (i < 3) drive(vec[i]);
      end
   endtask

   task automatic test_max_min();
      logic [65:0] vec[6] = '{
         {16'h1234, 16'hFFFE, 16'h0000, 16'h8000, 2'b01},
         {16'h1234, 16'hFFFE, 16'h0000, 16'h8000, 2'b10},
         {16'h5555, 16'h5555, 16'h5555, 16'h5555, 2'b01},
         {16'h5555, 16'h5555, 16'h5555, 16'h5555, 2'b10},
         {16'h0007, 16'h0003, 16'h9000, 16'h0002, 2'b01},
         {16'h0007, 16'h0003, 16'h9000, 16'h0002, 2'b10}};
      logic [15:0] got, exp;
      for (int i = 0; i <= 6; i++) begin
         @(negedge clk);
         if (i > 0) begin
            got = o_data;
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL maxmin[%0d]: scoreboard empty, o_data=%h", i - 1, got);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp) begin
                  n_fail++;
                  $display("FAIL maxmin[%0d]: o_data=%h expected %h", i - 1, got, exp);
               end
            end
         end
         if (i < 6) drive(vec[i]);
      end
   endtask

   task automatic test_avg();
      logic [65:0] vec[3] = '{
         {16'h0001, 16'h0001, 16'h0001, 16'h0002, 2'b11},
         {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2'b11},
         {16'h0003, 16'h0000, 16'h0000, 16'h0000, 2'b11}};
      logic [15:0] got, exp;
      for (int i = 0; i <= 3; i++) begin
         @(negedge clk);
         if (i > 0) begin
            got = o_data;
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL avg[%0d]: scoreboard empty, o_data=%h", i - 1, got);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp) begin
                  n_fail++;
                  $display("FAIL avg[%0d]: o_data=%h expected %h", i - 1, got, exp);
               end
            end
         end
         if (i < 3) drive(vec[i]);
      end
   endtask

   // Opcode sweep on fixed operands, then random vectors, all without bubbles.
   task automatic test_back_to_back();
      localparam int N = 28;
      logic [65:0] vec[N];
      logic [15:0] got, exp;
      for (int k = 0; k < 4; k++)
         vec[k] = {16'h0100, 16'hF000, 16'h0020, 16'h4000, 2'(k)};
      for (int k = 4; k < N; k++)
         vec[k] = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                   2'($urandom_range(3))};
      for (int i = 0; i <= N; i++) begin
         @(negedge clk);
         if (i > 0) begin
            got = o_data;
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL b2b[%0d]: scoreboard empty, o_data=%h", i - 1, got);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp) begin
                  n_fail++;
                  $display("FAIL b2b[%0d]: o_data=%h expected %h", i - 1, got, exp);
               end
            end
         end
         if (i < N) drive(vec[i]);
      end
   endtask

   task automatic test_async_reset();
      logic [15:0] got, exp;
      @(negedge clk);
      drive({16'h0001, 16'h0002, 16'h0003, 16'h0004, 2'b00});
      @(negedge clk);
      got = o_data;
      exp = exp_q.pop_front();
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL async_pre: o_data=%h expected %h", got, exp);
      end
      // Mid-cycle assertion, well before the next rising edge.
      #2 rst_n = 1'b0;
      #1 got = o_data;
      n_tests++;
      if (got !== 16'h0000) begin
         n_fail++;
         $display("FAIL async_clear: o_data=%h expected 0000", got);
      end
      @(posedge clk);
      #1 got = o_data;
      n_tests++;
      if (got !== 16'h0000) begin
         n_fail++;
         $display("FAIL async_hold: o_data=%h expected 0000", got);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive({16'hAAAA, 16'h0001, 16'h0002, 16'h0003, 2'b01});
      @(negedge clk);
      got = o_data;
      exp = exp_q.pop_front();
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL async_recover: o_data=%h expected %h", got, exp);
      end
   endtask

   initial begin
      test_reset();
      test_sum();
      test_max_min();
      test_avg();
      test_back_to_back();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/problem_quad_reduce.md
Name: problem_quad_reduce

Overview:
- Registered 4-input, 16-bit reduction unit.
- Each clock it samples four unsigned operands and a 2-bit opcode, computes sum, maximum, minimum or average of the operands, and registers the result.
- Sits in the datapath as a single-stage combine/select stage feeding downstream logic through the registered o_data.

Parameters:
- None. All widths are fixed: 16-bit data, 2-bit control.

Ports:
- i_clk  input  1  system clock; all state updates on rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_data_0  input  16  operand 0, unsigned.
- i_data_1  input  16  operand 1, unsigned.
- i_data_2  input  16  operand 2, unsigned.
- i_data_3  input  16  operand 3, unsigned.
- i_ctrl  input  2  opcode, sampled every rising edge.
- o_data  output  16  registered result.

Interface rule (already decided): one clock; reset is asynchronous and active-low. Clock port is i_clk, reset port is i_rst_n.

Behaviour:
- Reset:
  - i_rst_n low clears o_data to 16'h0000 immediately, independent of i_clk.
  - Output holds 0 while reset is asserted.
  - First update occurs on the first rising edge after deassertion.
- Latency: exactly 1 cycle. At rising edge k, o_data takes the function of i_data_0..3 and i_ctrl as sampled at edge k.
- No handshake; a new result every cycle. Inputs may change every cycle.
- All arithmetic is unsigned.
- Sum S = d0+d1+d2+d3, computed at 18-bit width (maximum 0x3FFFC); no intermediate overflow is permitted.
- Opcodes:
  - i_ctrl=2'b00 SUM: result per Optional Feature (saturate or wrap).
  - i_ctrl=2'b01 MAX: largest of the four operands. Ties return the equal value.
  - i_ctrl=2'b10 MIN: smallest of the four operands.
  - i_ctrl=2'b11 AVG: S >> 2, truncating (floor). Always fits 16 bits, never saturates.
- MAX/MIN use a 2-level comparator tree: (d0,d1), (d2,d3), then the winners.
- No other internal state; the block holds no memory beyond o_data.
- X/undefined opcode is not required to be handled. Synthesis must still fully decode all 4 codes with no latch.
- Reset asserted mid-operation discards any in-flight result; o_data goes to 0 asynchronously.

Optional Feature:
- Macro PROBLEM_SUM_SAT_EN.
- Defined: SUM saturates; if S > 16'hFFFF then o_data = 16'hFFFF, else S[15:0].
- Undefined (default): SUM wraps; o_data = S[15:0] (modulo 2^16).
- No other opcode is affected by the macro.

Test Plan:
- Reset: hold i_rst_n=0 with inputs nonzero, toggle clock -> o_data=0x0000. Assert reset asynchronously mid-cycle after a nonzero result -> o_data=0 before the next edge.
- SUM: d=0x0001,0x0002,0x0003,0x0004, ctrl=00 -> 0x000A one edge later. Then d=0xFFFF,0x0001,0,0 -> 0xFFFF with PROBLEM_SUM_SAT_EN, 0x0000 without.
- MAX/MIN: d=0x1234,0xFFFE,0x0000,0x8000; ctrl=01 -> 0xFFFE; ctrl=10 -> 0x0000. All-equal 0x5555 -> 0x5555 for both.
- AVG: d=1,1,1,2, ctrl=11 -> 0x0001 (truncated). All 0xFFFF -> 0xFFFF.
- Per-cycle switching: change ctrl 00->01->10->11 on consecutive edges with fixed operands -> o_data follows each opcode with exactly 1-cycle latency, no bubbles.
